// File: rtl/pll_seq_pkg.sv
// Purpose : shared types and constants for the PLL phase sequencer.
// Latency : n/a (package: state encoding, fixed counter select, parameter defaults).
// Backpressure: n/a.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SWITCH  = 3'd1,
        PLAN    = 3'd2,
        STEP    = 3'd3,
        WAIT_LO = 3'd4,
        WAIT_HI = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Phase steps are always applied to all PLL counters at once.
    localparam logic [2:0] PHASE_CNT_SEL = 3'b000;

    localparam int SCANCLK_HALF_DEF   = 4;
    localparam int SWITCH_CYCLES_DEF  = 8;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    // Shortest path around the 256-position phase ring: diff 1..128 is
    // walked upwards, 129..255 downwards in (256 - diff) steps.
    function automatic logic [7:0] step_count(input logic [7:0] diff);
        if (diff <= 8'd128)
            return diff;
        else
            return 8'd0 - diff;
    endfunction

endpackage

// File: rtl/pll_scanclk_gen.sv
// Purpose : divides clk into the PLL scan clock and flags the cycle before each edge.
// Latency : first scanclk toggle half_period cycles after enable rises; drops low one cycle after enable falls.
// Backpressure: none; free-running while enable is high.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   enable       run the divider; low forces scanclk low and clears the count
//   half_period  clk cycles per scanclk half-period (>= 2)
//   scanclk      divided clock (registered)
//   rise_pulse   high in the clk cycle at whose end scanclk goes 0 -> 1
//   fall_pulse   high in the clk cycle at whose end scanclk goes 1 -> 0
module pll_scanclk_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] half_period,
    output logic       scanclk,
    output logic       rise_pulse,
    output logic       fall_pulse
);

    logic [7:0] cnt;
    logic       hit;

    assign hit        = enable && (cnt == (half_period - 8'd1));
    assign rise_pulse = hit && !scanclk;
    assign fall_pulse = hit && scanclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            scanclk <= 1'b0;
        end else if (!enable) begin
            cnt     <= 8'd0;
            scanclk <= 1'b0;
        end else if (hit) begin
            cnt     <= 8'd0;
            scanclk <= ~scanclk;
        end else begin
            cnt     <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pll_phase_sequencer.sv
// Purpose : applies a requested PLL input-clock source and phase via clkswitch and phase-step handshakes.
// Latency : busy rises the cycle after updatepll; each step costs ~2 scanclk periods plus the PLL phasedone turnaround.
// Backpressure: none; requests arriving while busy coalesce into one pending request served from DONE.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   updatepll                  one-cycle request strobe; samples pll_clk_src / pll_clk_phase
//   pll_clk_src, pll_clk_phase requested source and phase (phase modulo 256)
//   phasedone                  PLL handshake, low while a step is in progress
//   phasecounterselect         constant all-counters select
//   phaseupdown, phasestep     step direction and strobe to the PLL
//   scanclk, clkswitch         PLL scan clock and clock-switch strobe
//   cur_src, cur_phase         setting last applied to the PLL
//   busy                       sequencer not idle
//   error                      sticky phasedone timeout (only with PLL_SEQ_TIMEOUT_EN)
//
// Build option: define PLL_SEQ_TIMEOUT_EN to enable the phasedone watchdog.
module pll_phase_sequencer #(
    parameter int SCANCLK_HALF   = pll_seq_pkg::SCANCLK_HALF_DEF,
    parameter int SWITCH_CYCLES  = pll_seq_pkg::SWITCH_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = pll_seq_pkg::TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       updatepll,
    input  logic       pll_clk_src,
    input  logic [7:0] pll_clk_phase,
    input  logic       phasedone,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       scanclk,
    output logic       clkswitch,
    output logic       cur_src,
    output logic [7:0] cur_phase,
    output logic       busy,
    output logic       error
);

    import pll_seq_pkg::*;

    localparam int             SW_W    = $clog2(SWITCH_CYCLES + 1);
    localparam logic [SW_W-1:0] SW_LAST = SW_W'(SWITCH_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic            tgt_src;
    logic [7:0]      tgt_phase;
    logic            pending;
    logic [7:0]      steps;
    logic [SW_W-1:0] sw_cnt;
    logic [1:0]      rise_cnt;
    logic [7:0]      diff;
    logic            req_src;
    logic            scan_en;
    logic            rise_pulse;
    logic            fall_pulse;
    logic            timeout;

    assign phasecounterselect = PHASE_CNT_SEL;
    assign diff               = tgt_phase - cur_phase;
    // In DONE a same-cycle request is served straight away, so its source
    // must be compared before it lands in tgt_src.
    assign req_src            = updatepll ? pll_clk_src : tgt_src;

    pll_scanclk_gen u_scanclk (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (scan_en),
        .half_period (8'(SCANCLK_HALF)),
        .scanclk     (scanclk),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse)
    );

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;

    assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);
    // A phasedone transition in the last allowed cycle still counts as success.
    assign timeout = in_wait && (wd_cnt == WD_LAST) &&
                     (((state == WAIT_LO) && phasedone) ||
                      ((state == WAIT_HI) && !phasedone));

    // Restarts for every step: only time spent waiting on the PLL is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            wd_cnt <= in_wait ? wd_cnt + 1'b1 : '0;
            if (timeout)
                error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (updatepll)
                    state_nxt = (pll_clk_src != cur_src) ? SWITCH : PLAN;
            end
            SWITCH: begin
                if (sw_cnt == SW_LAST)
                    state_nxt = PLAN;
            end
            PLAN: begin
                state_nxt = (diff == 8'd0) ? DONE : STEP;
            end
            STEP: begin
                if (fall_pulse && (rise_cnt == 2'd2))
                    state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (!phasedone)
                    state_nxt = WAIT_HI;
                else if (timeout)
                    state_nxt = DONE;
            end
            WAIT_HI: begin
                if (phasedone)
                    state_nxt = (steps == 8'd1) ? DONE : STEP;
                else if (timeout)
                    state_nxt = DONE;
            end
            DONE: begin
                if (pending || updatepll)
                    state_nxt = (req_src != cur_src) ? SWITCH : PLAN;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        phasestep = (state == STEP);
        clkswitch = (state == SWITCH);
        busy      = (state != IDLE);
        scan_en   = (state == STEP) || (state == WAIT_LO) || (state == WAIT_HI);
    end

    // Request capture and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_src     <= 1'b0;
            tgt_phase   <= 8'd0;
            pending     <= 1'b0;
            cur_src     <= 1'b0;
            cur_phase   <= 8'd0;
            steps       <= 8'd0;
            phaseupdown <= 1'b1;
            sw_cnt      <= '0;
            rise_cnt    <= 2'd0;
        end else begin
            if (updatepll) begin
                tgt_src   <= pll_clk_src;
                tgt_phase <= pll_clk_phase;
            end

            // DONE consumes whatever is pending (including a request arriving
            // in DONE itself); a timeout throws the pending request away.
            if (timeout || (state == DONE))
                pending <= 1'b0;
            else if (updatepll && (state != IDLE))
                pending <= 1'b1;

            sw_cnt <= (state == SWITCH) ? sw_cnt + 1'b1 : '0;
            if ((state == SWITCH) && (sw_cnt == SW_LAST))
                cur_src <= ~cur_src;

            // Direction is fixed here and held for the whole step sequence.
            if ((state == PLAN) && (diff != 8'd0)) begin
                phaseupdown <= (diff <= 8'd128);
                steps       <= step_count(diff);
            end

            if (state != STEP)
                rise_cnt <= 2'd0;
            else if (rise_pulse && (rise_cnt != 2'd2))
                rise_cnt <= rise_cnt + 2'd1;

            if ((state == WAIT_HI) && phasedone) begin
                cur_phase <= phaseupdown ? cur_phase + 8'd1 : cur_phase - 8'd1;
                steps     <= steps - 8'd1;
            end
        end
    end

endmodule
